// File: rtl/multiplier_16x16_core.sv
// Unsigned 16x16 -> 32 multiplier: radix-4 Booth partial products, CSA tree, final CPA.
// Define MULT16_PIPE_EN to register the CSA sum/carry vectors (latency 2 instead of 1).
module multiplier_16x16_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [31:0] product
);

  // Each row stores its partial product with the sign bit inverted (value + 2^17);
  // this constant is -sum(2^(17+2i)) mod 2^32 and removes that bias in one go.
  localparam logic [31:0] sign_comp = 32'h5556_0000;

  function automatic logic [63:0] csa3(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
    logic [31:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[30:0], 1'b0, x ^ y ^ z};
  endfunction

  logic [18:0]       bx;
  logic [8:0][31:0]  pp_row;
  logic [8:0]        neg_bit;
  logic [31:0]       neg_row;

  assign bx = {2'b00, b, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_booth
      logic [2:0]  trip;
      logic        one, two, neg;
      logic [17:0] mag, pp;

      assign trip = bx[2*gi+2 -: 3];
      assign one  = trip[1] ^ trip[0];
      assign two  = (trip == 3'b100) || (trip == 3'b011);
      // 3'b111 encodes -0; keep neg low so the row is a clean zero
      assign neg  = trip[2] & ~(trip[1] & trip[0]);
      assign mag  = one ? {2'b00, a} : (two ? {1'b0, a, 1'b0} : 18'd0);
      assign pp   = neg ? ~mag : mag;
      assign neg_bit[gi] = neg;
      assign pp_row[gi]  = {14'b0, ~pp[17], pp[16:0]} << (2 * gi);
    end
  endgenerate

  // Two's-complement +1 of negated rows lands on even bits below 17, clear of sign_comp
  always_comb begin
    neg_row = sign_comp;
    for (int i = 0; i < 9; i++) begin
      neg_row[2*i] = neg_bit[i];
    end
  end

  logic [9:0][31:0] l0;
  logic [6:0][31:0] l1;
  logic [4:0][31:0] l2;
  logic [3:0][31:0] l3;
  logic [2:0][31:0] l4;
  logic [31:0]      tree_sum, tree_carry;

  assign l0 = {neg_row, pp_row};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_lvl1
      assign {l1[2*gi+1], l1[2*gi]} = csa3(l0[3*gi], l0[3*gi+1], l0[3*gi+2]);
    end
  endgenerate
  assign l1[6] = l0[9];

  assign {l2[1], l2[0]} = csa3(l1[0], l1[1], l1[2]);
  assign {l2[3], l2[2]} = csa3(l1[3], l1[4], l1[5]);
  assign l2[4]          = l1[6];

  assign {l3[1], l3[0]} = csa3(l2[0], l2[1], l2[2]);
  assign l3[2]          = l2[3];
  assign l3[3]          = l2[4];

  assign {l4[1], l4[0]} = csa3(l3[0], l3[1], l3[2]);
  assign l4[2]          = l3[3];

  assign {tree_carry, tree_sum} = csa3(l4[0], l4[1], l4[2]);

  logic [31:0] product_next;
  logic        cpa_valid;

`ifdef MULT16_PIPE_EN
  logic [31:0] sum_reg, carry_reg;
  logic        valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= 32'd0;
      carry_reg <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= tree_sum;
        carry_reg <= tree_carry;
      end
    end
  end

  assign product_next = sum_reg + carry_reg;
  assign cpa_valid    = valid_reg;
`else
  assign product_next = tree_sum + tree_carry;
  assign cpa_valid    = in_valid;
`endif

  logic [31:0] product_reg;
  logic        out_valid_reg;

  // Product only loads on a valid pair, so idle operands (even X) never reach it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg   <= 32'd0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= cpa_valid;
      if (cpa_valid) begin
        product_reg <= product_next;
      end
    end
  end

  assign product   = product_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_multiplier_16x16_core.sv
// Bench for multiplier_16x16_core: a delay-line reference model of depth LAT checked every cycle.
// Build with MULT16_PIPE_EN defined to exercise the 2-cycle variant.
module tb_multiplier_16x16_core;

`ifdef MULT16_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [31:0] product;

  multiplier_16x16_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] p;
  } ent_t;

  ent_t        pipe_q[$];
  logic        exp_valid;
  logic [31:0] exp_prod;
  int          n_tests;
  int          n_fail;
  int          cyc;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] xx;
    logic [31:0] yy;
    xx = {16'b0, x};
    yy = {16'b0, y};
    return xx * yy;
  endfunction

  task automatic model_reset();
    ent_t e;
    pipe_q.delete();
    e.v = 1'b0;
    e.p = 32'd0;
    for (int i = 0; i < LAT - 1; i++) pipe_q.push_back(e);
    exp_valid = 1'b0;
    exp_prod  = 32'd0;
  endtask

  // Drive one pair, advance past the edge, and update the expected outputs.
  task automatic cycle(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic [31:0] pexp);
    ent_t e;
    ent_t o;
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    cyc++;
    e.v = v;
    e.p = pexp;
    pipe_q.push_back(e);
    o = pipe_q.pop_front();
    exp_valid = o.v;
    if (o.v) exp_prod = o.p;
    $display("[TB] cyc %0d in_valid=%b a=%h b=%h -> out_valid=%b product=%h", cyc, v, av, bv,
             out_valid, product);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'($urandom);
    b        = 16'($urandom);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (product !== 32'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: product=%h out_valid=%b, required product=00000000 out_valid=0",
                 i, product, out_valid);
      end
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      n_tests++;
      if (product !== 32'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle[%0d]: product=%h out_valid=%b, required 00000000/0",
                 i, product, out_valid);
      end
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [6] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000, 16'hFFFF, 16'h0000};
    logic [15:0] vb [6] = '{16'h0001, 16'h0002, 16'h5678, 16'h8000, 16'hFFFF, 16'hABCD};
    logic [31:0] vp [6] = '{32'h0000_0001, 32'h0001_FFFE, 32'h0626_0060,
                            32'h4000_0000, 32'hFFFE_0001, 32'h0000_0000};
    for (int i = 0; i < 6 + LAT; i++) begin
      if (i < 6) cycle(1'b1, va[i], vb[i], vp[i]);
      else       cycle(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      n_tests++;
      if (out_valid !== exp_valid || product !== exp_prod) begin
        n_fail++;
        $display("FAIL directed[%0d]: product=%h out_valid=%b, required product=%h out_valid=%b",
                 i, product, out_valid, exp_prod, exp_valid);
      end
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 16'h1234, 16'h5678, 32'h0626_0060);
    for (int i = 0; i < 3 + LAT - 1; i++) begin
      if (i > 0) cycle(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      n_tests++;
      if (out_valid !== exp_valid || product !== exp_prod) begin
        n_fail++;
        $display("FAIL hold[%0d]: product=%h out_valid=%b, required product=%h out_valid=%b",
                 i, product, out_valid, exp_prod, exp_valid);
      end
      if (i >= LAT) begin
        n_tests++;
        if (product !== 32'h0626_0060 || out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_value[%0d]: product=%h out_valid=%b, required 06260060/0",
                   i, product, out_valid);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int          valid_seen;
    logic [15:0] av, bv;
    valid_seen = 0;
    for (int i = 0; i < 1000 + LAT; i++) begin
      if (i < 1000) begin
        case ($urandom_range(0, 9))
          0:       av = 16'hFFFF;
          1:       av = 16'h8000;
          default: av = 16'($urandom);
        endcase
        case ($urandom_range(0, 9))
          0:       bv = 16'hFFFF;
          1:       bv = 16'h8000;
          2:       bv = 16'h5555;
          default: bv = 16'($urandom);
        endcase
        cycle(1'b1, av, bv, ref_mul(av, bv));
      end else begin
        cycle(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      end
      if (out_valid === 1'b1) valid_seen++;
      n_tests++;
      if (out_valid !== exp_valid || product !== exp_prod) begin
        n_fail++;
        $display("FAIL stream[%0d]: product=%h out_valid=%b, required product=%h out_valid=%b",
                 i, product, out_valid, exp_prod, exp_valid);
      end
    end
    n_tests++;
    if (valid_seen !== 1000) begin
      n_fail++;
      $display("FAIL stream_count: out_valid pulses=%0d, required 1000", valid_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] av, bv;
    for (int i = 0; i < 3; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      cycle(1'b1, av, bv, ref_mul(av, bv));
    end
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (product !== 32'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: product=%h out_valid=%b, required 00000000/0", product, out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
      n_tests++;
      if (product !== 32'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_held[%0d]: product=%h out_valid=%b, required 00000000/0",
                 i, product, out_valid);
      end
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      cycle(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      n_tests++;
      if (product !== 32'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale[%0d]: product=%h out_valid=%b, required 00000000/0",
                 i, product, out_valid);
      end
    end
    for (int i = 0; i < 1 + LAT; i++) begin
      if (i == 0) cycle(1'b1, 16'hFFFF, 16'h8000, 32'h7FFF_8000);
      else        cycle(1'b0, 16'($urandom), 16'($urandom), 32'd0);
      n_tests++;
      if (out_valid !== exp_valid || product !== exp_prod) begin
        n_fail++;
        $display("FAIL reset_recover[%0d]: product=%h out_valid=%b, required product=%h out_valid=%b",
                 i, product, out_valid, exp_prod, exp_valid);
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 16'd0;
    b        = 16'd0;
    model_reset();
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
